// File: rtl/adex_spike_monitor.sv
// adex_spike_monitor: spike detector, ISI, windowed rate and event FIFO.
// Consumes the AdEx neuron state (v, u) and reports threshold-crossing spikes.
//
// Ports:
//   clk, reset        single clock, synchronous active-high reset
//   v, u              signed neuron state samples (16 bit)
//   spike             one-cycle pulse per detected spike
//   isi, isi_valid    cycles between the last two spikes; valid after two spikes
//   rate_count        spikes counted in the last completed window
//   rate_valid        one-cycle pulse when rate_count updates
//   ev_valid/ev_ready head of the event FIFO, handshake with the consumer
//   ev_ts, ev_u       head event timestamp and u sample (zero when empty)
//   overflow          sticky flag, set when an event is dropped
//   drop_count        dropped-event count, saturating at 255
module adex_spike_monitor #(
    parameter logic signed [15:0] V_THRESH       = 16'sd30,
    parameter logic signed [15:0] V_REARM        = -16'sd40,
    parameter int                 REFRACT_CYCLES = 8,
    parameter int                 WINDOW_CYCLES  = 1000,
    parameter int                 TS_W           = 32,
    parameter int                 CNT_W          = 16,
    parameter int                 FIFO_DEPTH     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [15:0]      v,
    input  logic [15:0]      u,
    output logic             spike,
    output logic [TS_W-1:0]  isi,
    output logic             isi_valid,
    output logic [CNT_W-1:0] rate_count,
    output logic             rate_valid,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [TS_W-1:0]  ev_ts,
    output logic [15:0]      ev_u,
    output logic             overflow,
    output logic [7:0]       drop_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int RW = $clog2(REFRACT_CYCLES + 1);
    localparam int WW = $clog2(WINDOW_CYCLES);
    localparam int EW = TS_W + 16;

    localparam logic [PW:0]   FULL_CNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [RW-1:0] RCNT_LD  = RW'(REFRACT_CYCLES - 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);

    typedef enum logic [1:0] {
        ARMED,
        REFRACT,
        WAIT_REARM
    } state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    rcnt_q, rcnt_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [TS_W-1:0]  last_ts_q, last_ts_d;
    logic             seen_q, seen_d;
    logic             spike_q, spike_d;
    logic [TS_W-1:0]  isi_q, isi_d;
    logic             isi_valid_q, isi_valid_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [CNT_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] rate_count_q, rate_count_d;
    logic             rate_valid_q, rate_valid_d;
    logic [EW-1:0]    mem_q [FIFO_DEPTH];
    logic [EW-1:0]    mem_d [FIFO_DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             overflow_q, overflow_d;
    logic [7:0]       drop_q, drop_d;

    logic             v_hi;
    logic             v_lo;
    logic             fire;
    logic             pop;
    logic             push;
    logic [CNT_W-1:0] acc_inc;
    logic [EW-1:0]    head;

    assign v_hi = $signed(v) >= V_THRESH;
    assign v_lo = $signed(v) < V_REARM;

    // Detection FSM: refractory countdown, then wait for v to re-arm.
    always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        fire    = 1'b0;
        unique case (state_q)
            ARMED: begin
                if (v_hi) begin
                    fire    = 1'b1;
                    rcnt_d  = RCNT_LD;
                    state_d = REFRACT;
                end
            end
            REFRACT: begin
                if (rcnt_q == '0) begin
                    state_d = v_lo ? ARMED : WAIT_REARM;
                end else begin
                    rcnt_d = rcnt_q - RW'(1);
                end
            end
            WAIT_REARM: begin
                if (v_lo) begin
                    state_d = ARMED;
                end
            end
            default: state_d = ARMED;
        endcase
    end

    // Timestamp, ISI and windowed rate.
    always_comb begin
        ts_d         = ts_q + TS_W'(1);
        last_ts_d    = last_ts_q;
        seen_d       = seen_q;
        spike_d      = fire;
        isi_d        = isi_q;
        isi_valid_d  = isi_valid_q;
        rate_count_d = rate_count_q;
        rate_valid_d = 1'b0;

        if (fire) begin
            last_ts_d = ts_q;
            seen_d    = 1'b1;
            if (seen_q) begin
                // modular difference handles timestamp wrap
                isi_d       = ts_q - last_ts_q;
                isi_valid_d = 1'b1;
            end
        end

        acc_inc = acc_q;
        if (fire && (acc_q != '1)) begin
            acc_inc = acc_q + CNT_W'(1);
        end

        if (wcnt_q == WIN_LAST) begin
            wcnt_d       = '0;
            rate_count_d = acc_inc;
            rate_valid_d = 1'b1;
            acc_d        = '0;
        end else begin
            wcnt_d = wcnt_q + WW'(1);
            acc_d  = acc_inc;
        end
    end

    // Event FIFO: a pop on a full FIFO frees the slot for a same-cycle push.
    always_comb begin
        mem_d      = mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        overflow_d = overflow_q;
        drop_d     = drop_q;
        pop        = (cnt_q != '0) && ev_ready;
        push       = 1'b0;

        if (fire) begin
            if ((cnt_q != FULL_CNT) || pop) begin
                push          = 1'b1;
                mem_d[wptr_q] = {ts_q, u};
                wptr_d        = wptr_q + PW'(1);
            end else begin
                overflow_d = 1'b1;
                if (drop_q != 8'hff) begin
                    drop_d = drop_q + 8'd1;
                end
            end
        end

        if (pop) begin
            rptr_d = rptr_q + PW'(1);
        end

        if (push && !pop) begin
            cnt_d = cnt_q + (PW + 1)'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - (PW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ARMED;
            rcnt_q       <= '0;
            ts_q         <= '0;
            last_ts_q    <= '0;
            seen_q       <= 1'b0;
            spike_q      <= 1'b0;
            isi_q        <= '0;
            isi_valid_q  <= 1'b0;
            wcnt_q       <= '0;
            acc_q        <= '0;
            rate_count_q <= '0;
            rate_valid_q <= 1'b0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            cnt_q        <= '0;
            overflow_q   <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            rcnt_q       <= rcnt_d;
            ts_q         <= ts_d;
            last_ts_q    <= last_ts_d;
            seen_q       <= seen_d;
            spike_q      <= spike_d;
            isi_q        <= isi_d;
            isi_valid_q  <= isi_valid_d;
            wcnt_q       <= wcnt_d;
            acc_q        <= acc_d;
            rate_count_q <= rate_count_d;
            rate_valid_q <= rate_valid_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            cnt_q        <= cnt_d;
            overflow_q   <= overflow_d;
            drop_q       <= drop_d;
        end
    end

    // Storage needs no reset: the head is masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head       = mem_q[rptr_q];
    assign ev_valid   = (cnt_q != '0);
    assign ev_ts      = ev_valid ? head[EW-1:16] : '0;
    assign ev_u       = ev_valid ? head[15:0] : '0;
    assign spike      = spike_q;
    assign isi        = isi_q;
    assign isi_valid  = isi_valid_q;
    assign rate_count = rate_count_q;
    assign rate_valid = rate_valid_q;
    assign overflow   = overflow_q;
    assign drop_count = drop_q;

endmodule

// File: doc/adex_spike_monitor.md
Name: adex_spike_monitor

Overview:
- Downstream consumer of the AdEx neuron state outputs (v, u).
- Detects spikes as threshold crossings of v, with refractory and re-arm hysteresis.
- Emits a one-cycle spike pulse, the inter-spike interval (ISI) and a windowed spike count.
- Buffers timestamped spike events (timestamp plus u at the spike) in a small FIFO with a valid/ready output, for readout logic or a logging bench.

Parameters:
- V_THRESH, 16'sd30: signed spike threshold on v (v >= V_THRESH fires).
- V_REARM, -16'sd40: signed re-arm level; v must fall strictly below it before the next spike.
- REFRACT_CYCLES, 8: minimum cycles after a spike before re-arm is checked (>=1).
- WINDOW_CYCLES, 1000: length of the rate-count window in cycles (>=2).
- TS_W, 32: timestamp and ISI width.
- CNT_W, 16: window spike-count width.
- FIFO_DEPTH, 8: event FIFO entries (power of 2).

Ports:
- clk, in, 1: single clock.
- reset, in, 1: synchronous, active-high reset.
- v, in, 16: signed membrane potential from the neuron.
- u, in, 16: signed adaptation variable from the neuron.
- spike, out, 1: one-cycle pulse per detected spike.
- isi, out, TS_W: cycles between the last two spikes; updated with spike.
- isi_valid, out, 1: high once two spikes have occurred since reset.
- rate_count, out, CNT_W: spikes in the last completed window.
- rate_valid, out, 1: one-cycle pulse when rate_count updates.
- ev_valid, out, 1: FIFO head valid.
- ev_ready, in, 1: consumer accepts the head.
- ev_ts, out, TS_W: head event timestamp.
- ev_u, out, 16: head event u sample.
- overflow, out, 1: sticky; set when an event is dropped.
- drop_count, out, 8: dropped-event count, saturating at 255.

Behaviour:
- Reset (sync, at an edge with reset=1):
  - All outputs 0, FIFO empty, ts counter 0, window counter 0.
  - FSM goes to ARMED; no spike "seen" yet.
  - Reset overrides all other activity in that cycle.
  - Reset mid-refractory or mid-window discards all state.
- Timestamp: ts increments by 1 every non-reset cycle and wraps modulo 2^TS_W.
- Edge E convention: the spike is detected at edge E, and ts_E is the ts value before E.
- FSM:
  - ARMED: if v >= V_THRESH (signed compare) at edge E, then:
    - spike=1 for the cycle after E;
    - rcnt loads REFRACT_CYCLES-1;
    - go to REFRACT.
  - REFRACT: rcnt decrements each cycle, and spikes are ignored. At rcnt==0:
    - if v < V_REARM, go to ARMED;
    - otherwise go to WAIT_REARM.
  - WAIT_REARM: go to ARMED when v < V_REARM. v >= V_THRESH is ignored.
  - Result: minimum spacing between spikes is REFRACT_CYCLES+1 cycles.
- ISI:
  - On each spike, isi <= ts_E - last_ts (modulo 2^TS_W, so wrap is handled), then last_ts <= ts_E.
  - The first spike after reset only records last_ts; isi stays 0.
  - isi_valid rises with the second spike and stays high until reset.
- Window:
  - wcnt counts 0..WINDOW_CYCLES-1.
  - At the edge where wcnt==WINDOW_CYCLES-1:
    - rate_count <= accumulated count, including a spike detected at that same edge;
    - rate_valid=1 for one cycle;
    - the accumulator clears to 0.
  - The accumulator saturates at 2^CNT_W-1.
- FIFO:
  - Push of {ts_E, u sampled at E} at the same edge E as spike.
  - ev_valid is high the cycle after E if the FIFO was empty.
  - Pop when ev_valid && ev_ready.
  - Full with a simultaneous pop: the push is accepted and occupancy is unchanged.
  - Full without a pop: the event is dropped, overflow <= 1 (sticky), and drop_count increments, saturating at 255.
  - ev_ts and ev_u hold stable while ev_valid && !ev_ready.
  - FIFO order is strict first-in, first-out.
- Spike detection and ISI never stall on FIFO backpressure.

Test Plan:
- Threshold and pulse: reset for 1 cycle, then v=-70. At ts=20 drive v=30 for 1 cycle, then v=-70.
  -> spike high exactly 1 cycle; ev_valid with ev_ts=20 and ev_u equal to the driven u; isi_valid=0.
- Refractory and hysteresis: hold v=35 for 50 cycles after a spike.
  -> exactly one spike. Then drop v to -39 and back to 35: no spike. Then drop v to -41 and back to 35: second spike.
- ISI: spikes at ts=20 and ts=120, with a valid re-arm between them.
  -> isi=100 and isi_valid=1 in the cycle after the second spike.
- Window with WINDOW_CYCLES=1000: 3 spikes in the first window, one of them at window edge ts=999.
  -> rate_valid pulse with rate_count=3; the next window starts at 0.
- Backpressure: ev_ready=0, 10 spikes with FIFO_DEPTH=8.
  -> 8 entries retained in order, drop_count=2, overflow=1. Then ev_ready=1 drains the oldest-first timestamps.
- Reset mid-refractory (state REFRACT, 3 entries queued).
  -> the cycle after reset: FIFO empty, ev_valid=0, isi_valid=0, and v>=V_THRESH fires immediately in ARMED.
